// File: rtl/gray_packer_pkg.sv
// Shared image-pipeline definitions: gray weights, packer states, channel expansion.
package gray_packer_pkg;

  // BT.601-style luma weights in 8.8 fixed point; they sum to 256
  localparam logic [7:0] GRAY_COEF_R = 8'd77;
  localparam logic [7:0] GRAY_COEF_G = 8'd150;
  localparam logic [7:0] GRAY_COEF_B = 8'd29;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } packer_state_e;

  // Widen a 5-bit channel to 8 bits by replicating its top bits
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Widen a 6-bit channel to 8 bits by replicating its top bits
  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/rgb565_to_gray.sv
// Combinational RGB565 to 8-bit gray conversion.
module rgb565_to_gray
  import gray_packer_pkg::*;
(
  input  logic [15:0] rgb_i,
  output logic [7:0]  gray_o
);

  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] sum;

  // Expand each channel to 8 bits, weight and drop the 8 fractional bits
  always_comb begin
    r8     = expand5(rgb_i[15:11]);
    g8     = expand6(rgb_i[10:5]);
    b8     = expand5(rgb_i[4:0]);
    sum    = ({8'd0, GRAY_COEF_R} * {8'd0, r8})
           + ({8'd0, GRAY_COEF_G} * {8'd0, g8})
           + ({8'd0, GRAY_COEF_B} * {8'd0, b8});
    gray_o = 8'(sum >> 8);
  end

endmodule

// File: rtl/gray_packer.sv
// Converts a framed RGB565 pixel stream to gray and packs four pixels per 32-bit word.
module gray_packer
  import gray_packer_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_valid,
  output logic        img_ready,
  input  logic        img_sync,
  input  logic [15:0] img_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sync,
  output logic        out_last,
  output logic        frame_err
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_WORD0_END = COL_W'(3);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);

  packer_state_e    state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [23:0]      lanes_q, lanes_d;
  logic             outValid_q, outValid_d;
  logic [31:0]      outData_q, outData_d;
  logic             outSync_q, outSync_d;
  logic             outLast_q, outLast_d;
  logic             frameErr_q, frameErr_d;
  logic [7:0]       gray;
  logic             accept;
  logic             frameStart;

  rgb565_to_gray u_gray (
    .rgb_i  (img_data),
    .gray_o (gray)
  );

  // Only the fourth lane needs room in the output register; it may complete as the held word drains
  always_comb begin
    img_ready = (state_q == WAIT_SYNC) || (lane_q != 2'd3) || !outValid_q || out_ready;
  end

  // Next-state logic: frame tracking, lane fill, word hand-off and sync-error restart
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    col_d      = col_q;
    row_d      = row_q;
    lanes_d    = lanes_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSync_d  = outSync_q;
    outLast_d  = outLast_q;
    frameErr_d = 1'b0;
    accept     = img_valid && img_ready;
    frameStart = 1'b0;

    if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end

    case (state_q)
      WAIT_SYNC: begin
        if (accept && img_sync) begin
          frameStart = 1'b1;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (img_sync && !((row_q == '0) && (col_q == '0))) begin
            frameErr_d = 1'b1;
            frameStart = 1'b1;
          end else begin
            case (lane_q)
              2'd0: lanes_d[7:0]   = gray;
              2'd1: lanes_d[15:8]  = gray;
              2'd2: lanes_d[23:16] = gray;
              default: begin
                outData_d  = {gray, lanes_q};
                outValid_d = 1'b1;
                outSync_d  = (row_q == '0) && (col_q == COL_WORD0_END);
                outLast_d  = (col_q == COL_LAST);
              end
            endcase
            lane_d = lane_q + 2'd1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d   = '0;
                state_d = WAIT_SYNC;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase

    if (frameStart) begin
      lanes_d[7:0] = gray;
      lane_d       = 2'd1;
      col_d        = COL_W'(1);
      row_d        = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_SYNC;
      lane_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      lanes_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSync_q  <= 1'b0;
      outLast_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      col_q      <= col_d;
      row_q      <= row_d;
      lanes_q    <= lanes_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSync_q  <= outSync_d;
      outLast_q  <= outLast_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_sync  = outSync_q;
  assign out_last  = outLast_q;
  assign frame_err = frameErr_q;

endmodule
